// File: rtl/msx_bus_cycle.sv
// Turns filtered MSX slot strobes into one-clk mem/IO read/write requests and runs the read handshake.
// Latency: request pulse on the clk after the qualifying ena edge; read data drives on the clk after rd_ack.
// Backpressure: no new bus cycle is accepted until the current strobes are released on an ena tick.
module msx_bus_cycle #(
    parameter int ADDR_W     = 16,
    parameter int RD_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ena,
    input  logic              sltsl_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    input  logic [7:0]        rdata,
    input  logic              rd_ack,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic              io_rd_req,
    output logic              io_wr_req,
    output logic [ADDR_W-1:0] addr_q,
    output logic [7:0]        wdata_q,
    output logic [7:0]        rdata_q,
    output logic              data_oe,
    output logic              rd_timeout,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD_WAIT,
        RD_DRIVE,
        RELEASE
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    state_t     state;
    logic [7:0] to_cnt;
    logic       cyc_rd;

    logic q_mem_rd, q_mem_wr, q_io_rd, q_io_wr, q_any;

    // IO cycles with M1 low are interrupt acknowledges and are never decoded.
    assign q_mem_rd = ~sltsl_n & ~mreq_n & iorq_n & ~rd_n &  wr_n;
    assign q_mem_wr = ~sltsl_n & ~mreq_n & iorq_n &  rd_n & ~wr_n;
    assign q_io_rd  = ~iorq_n  &  mreq_n & m1_n   & ~rd_n &  wr_n;
    assign q_io_wr  = ~iorq_n  &  mreq_n & m1_n   &  rd_n & ~wr_n;
    assign q_any    = q_mem_rd | q_mem_wr | q_io_rd | q_io_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            to_cnt     <= 8'd0;
            cyc_rd     <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            io_rd_req  <= 1'b0;
            io_wr_req  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'hFF;
            data_oe    <= 1'b0;
            rd_timeout <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            io_rd_req  <= 1'b0;
            io_wr_req  <= 1'b0;
            rd_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (ena && q_any) begin
                        addr_q     <= addr;
                        if (q_mem_wr || q_io_wr)
                            wdata_q <= data_in;
                        mem_rd_req <= q_mem_rd;
                        mem_wr_req <= q_mem_wr;
                        io_rd_req  <= q_io_rd;
                        io_wr_req  <= q_io_wr;
                        cyc_rd     <= q_mem_rd | q_io_rd;
                        busy       <= 1'b1;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    to_cnt <= 8'd0;
                    state  <= cyc_rd ? RD_WAIT : RELEASE;
                end

                RD_WAIT: begin
                    // A strobe release beats a simultaneous ack; an ack beats the timeout.
                    if (ena && rd_n) begin
                        rd_timeout <= 1'b1;
                        state      <= RELEASE;
                    end else if (rd_ack) begin
                        rdata_q <= rdata;
                        data_oe <= 1'b1;
                        state   <= RD_DRIVE;
                    end else if (ena) begin
                        to_cnt <= to_cnt + 8'd1;
                        if (to_cnt == TO_LAST) begin
                            rd_timeout <= 1'b1;
                            state      <= RELEASE;
                        end
                    end
                end

                RD_DRIVE: begin
                    if (ena && rd_n) begin
                        data_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                RELEASE: begin
                    if (ena && rd_n && wr_n) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    data_oe <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msx_bus_cycle.sv
// Bench for msx_bus_cycle: directed and randomized bus cycles, outcomes predicted per transaction
// from ack timing, ena tick counts and strobe release.
module tb_msx_bus_cycle;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena;
    logic        sltsl_n, mreq_n, iorq_n, m1_n, rd_n, wr_n;
    logic [15:0] addr;
    logic [7:0]  data_in, rdata;
    logic        rd_ack;
    logic        mem_rd_req, mem_wr_req, io_rd_req, io_wr_req;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q, rdata_q;
    logic        data_oe, rd_timeout, busy;
    logic [3:0]  reqs;

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_exp  = 16'h0000;
    logic [7:0]  wdata_exp = 8'h00;
    logic [7:0]  rdata_exp = 8'hFF;

    assign reqs = {mem_rd_req, mem_wr_req, io_rd_req, io_wr_req};

    msx_bus_cycle #(.ADDR_W(16), .RD_TIMEOUT(T)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ena        (ena),
        .sltsl_n    (sltsl_n),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .m1_n       (m1_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .addr       (addr),
        .data_in    (data_in),
        .rdata      (rdata),
        .rd_ack     (rd_ack),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .io_rd_req  (io_rd_req),
        .io_wr_req  (io_wr_req),
        .addr_q     (addr_q),
        .wdata_q    (wdata_q),
        .rdata_q    (rdata_q),
        .data_oe    (data_oe),
        .rd_timeout (rd_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $error("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        sltsl_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rd_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_reqs"}, 32'(reqs), 32'd0);
        chk({tag, "_addr"}, 32'(addr_q), 32'd0);
        chk({tag, "_wdata"}, 32'(wdata_q), 32'h00);
        chk({tag, "_rdata"}, 32'(rdata_q), 32'hFF);
        chk({tag, "_oe"}, 32'(data_oe), 32'd0);
        chk({tag, "_to"}, 32'(rd_timeout), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ack_at: wait clk on which rd_ack is offered (0 = never); rel_at: wait clk on which rd_n is released early (0 = never)
    task automatic do_read(input logic io, input logic [15:0] a_addr, input logic [7:0] a_data,
                           input int ack_at, input bit rand_ena, input int rel_at);
        int cnt;
        int outcome;
        set_idle();
        if (io) begin
            iorq_n = 1'b0; mreq_n = 1'b1; m1_n = 1'b1; sltsl_n = 1'($urandom);
        end else begin
            sltsl_n = 1'b0; mreq_n = 1'b0; iorq_n = 1'b1; m1_n = 1'($urandom);
        end
        rd_n = 1'b0; wr_n = 1'b1; addr = a_addr; data_in = 8'($urandom); ena = 1'b1;
        step();
        addr_exp = a_addr;
        chk("rd_req", 32'(reqs), io ? 32'b0010 : 32'b1000);
        chk("rd_addr", 32'(addr_q), 32'(addr_exp));
        chk("rd_busy", 32'(busy), 32'd1);
        ena = 1'($urandom); addr = 16'($urandom);
        step();
        chk("rd_req_once", 32'(reqs), 32'd0);
        cnt = 0;
        outcome = 0;
        for (int k = 1; k <= 64 && outcome == 0; k++) begin
            ena    = rand_ena ? 1'($urandom) : 1'b1;
            rd_ack = (k == ack_at);
            rdata  = rd_ack ? a_data : 8'($urandom);
            if (k == rel_at) begin
                ena  = 1'b1;
                rd_n = 1'b1;
            end
            step();
            if (k == rel_at)
                outcome = 2;
            else if (k == ack_at)
                outcome = 1;
            else if (ena) begin
                cnt++;
                if (cnt == T)
                    outcome = 2;
            end
            chk("rd_wait_oe", 32'(data_oe), 32'(outcome == 1));
            chk("rd_wait_to", 32'(rd_timeout), 32'(outcome == 2));
        end
        chk("rd_resolved", 32'(outcome != 0), 32'd1);
        rd_ack = 1'b0;
        if (outcome == 1)
            rdata_exp = a_data;
        chk("rd_rdata", 32'(rdata_q), 32'(rdata_exp));
        chk("rd_addr_hold", 32'(addr_q), 32'(addr_exp));
        chk("rd_wdata_hold", 32'(wdata_q), 32'(wdata_exp));
        if (outcome == 1) begin
            for (int i = 0; i < 2; i++) begin
                ena = 1'b1; rd_ack = 1'($urandom); rdata = 8'($urandom);
                step();
                chk("drv_oe_held", 32'(data_oe), 32'd1);
                chk("drv_rdata", 32'(rdata_q), 32'(rdata_exp));
            end
            rd_ack = 1'b0; rd_n = 1'b1; ena = 1'b0;
            step();
            chk("drv_no_ena_oe", 32'(data_oe), 32'd1);
            chk("drv_no_ena_busy", 32'(busy), 32'd1);
            ena = 1'b1;
            step();
            chk("drv_release_oe", 32'(data_oe), 32'd0);
            chk("drv_release_busy", 32'(busy), 32'd0);
        end else begin
            ena = 1'b0;
            step();
            chk("to_pulse_end", 32'(rd_timeout), 32'd0);
            chk("to_busy", 32'(busy), 32'd1);
            chk("to_oe", 32'(data_oe), 32'd0);
            rd_n = 1'b1; ena = 1'b1;
            step();
            chk("to_release_busy", 32'(busy), 32'd0);
        end
        set_idle();
    endtask

    task automatic do_write(input logic io, input logic [15:0] a_addr, input logic [7:0] a_data, input int hold);
        set_idle();
        if (io) begin
            iorq_n = 1'b0; mreq_n = 1'b1; m1_n = 1'b1; sltsl_n = 1'($urandom);
        end else begin
            sltsl_n = 1'b0; mreq_n = 1'b0; iorq_n = 1'b1; m1_n = 1'($urandom);
        end
        rd_n = 1'b1; wr_n = 1'b0; addr = a_addr; data_in = a_data; ena = 1'b1;
        step();
        addr_exp  = a_addr;
        wdata_exp = a_data;
        chk("wr_req", 32'(reqs), io ? 32'b0001 : 32'b0100);
        chk("wr_addr", 32'(addr_q), 32'(addr_exp));
        chk("wr_wdata", 32'(wdata_q), 32'(wdata_exp));
        chk("wr_busy", 32'(busy), 32'd1);
        data_in = 8'($urandom); addr = 16'($urandom);
        for (int i = 0; i <= hold; i++) begin
            ena = 1'($urandom); rd_ack = 1'($urandom); rdata = 8'($urandom);
            step();
            chk("wr_hold_reqs", 32'(reqs), 32'd0);
            chk("wr_hold_busy", 32'(busy), 32'd1);
            chk("wr_hold_oe", 32'(data_oe), 32'd0);
            chk("wr_hold_wdata", 32'(wdata_q), 32'(wdata_exp));
        end
        rd_ack = 1'b0; wr_n = 1'b1; ena = 1'b0;
        step();
        chk("wr_no_ena_busy", 32'(busy), 32'd1);
        ena = 1'b1;
        step();
        chk("wr_release_busy", 32'(busy), 32'd0);
        chk("wr_rdata_hold", 32'(rdata_q), 32'(rdata_exp));
        set_idle();
    endtask

    task automatic ignored(input string tag, input logic s, input logic mr, input logic io,
                           input logic m1, input logic r, input logic w, input logic e);
        sltsl_n = s; mreq_n = mr; iorq_n = io; m1_n = m1; rd_n = r; wr_n = w; ena = e;
        addr = 16'($urandom); data_in = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_reqs"}, 32'(reqs), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
        chk({tag, "_addr"}, 32'(addr_q), 32'(addr_exp));
        set_idle();
        ena = 1'b1;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        ena = 1'b0; addr = 16'h0000; data_in = 8'h00; rdata = 8'h00;
        repeat (3) step();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        ena = 1'b1;
        step();

        do_read(1'b0, 16'h5A5A, 8'h11, 0, 1'b0, 0);     // timeout with constant ena, rdata_q stays FF
        chk("timeout_rdata_ff", 32'(rdata_q), 32'hFF);
        do_read(1'b0, 16'h4000, 8'hA5, 2, 1'b0, 0);
        do_write(1'b1, 16'h0098, 8'h3C, 5);
        ignored("ill_rdwr", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ignored("ill_intack", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        ignored("ill_mreq_iorq", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        ignored("other_slot", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        ignored("ena_low", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_read(1'b1, 16'h00A8, 8'h7E, T, 1'b0, 0);      // ack coincides with last tick
        do_read(1'b0, 16'h8123, 8'h42, 3, 1'b0, 3);      // early release beats ack
        do_read(1'b1, 16'h0010, 8'h99, 0, 1'b0, 4);      // early release, no ack

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_read(1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 20), 1'b1,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0);
            else
                do_write(1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 4));
        end

        // reset while driving read data
        set_idle();
        sltsl_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; addr = 16'h6000; ena = 1'b1;
        step();
        step();
        rd_ack = 1'b1; rdata = 8'h5A;
        step();
        chk("mid_drive_oe", 32'(data_oe), 32'd1);
        rd_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        set_idle();
        step();
        reset_n = 1'b1;
        addr_exp = 16'h0000; wdata_exp = 8'h00; rdata_exp = 8'hFF;
        step();
        chk_reset_vals("post_reset");
        do_read(1'b0, 16'h4321, 8'hC3, 5, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
